word_framer: RTL and testbench



---
 rtl/word_framer_if.sv | 29 ++
 rtl/word_framer.sv | 167 ++++++++++++++++
 tb/tb_word_framer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/word_framer_if.sv
// Handshake bundle between the word clipper, the framer and the MFCC memory reader.
// The framer takes the slave view; the upstream/downstream driver takes the master view.
interface word_framer_if;
  logic        i_start;
  logic [31:0] i_start_addr;
  logic [31:0] i_end_addr;
  logic        o_ready;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_frame_start;
  logic [31:0] o_frame_end;
  logic [15:0] o_frame_idx;
  logic        o_last;
  logic        o_done;
  logic        o_err;
  logic [15:0] o_frame_count;

  modport slave (
    input  i_start, i_start_addr, i_end_addr, i_ready,
    output o_ready, o_valid, o_frame_start, o_frame_end, o_frame_idx,
           o_last, o_done, o_err, o_frame_count
  );

  modport master (
    output i_start, i_start_addr, i_end_addr, i_ready,
    input  o_ready, o_valid, o_frame_start, o_frame_end, o_frame_idx,
           o_last, o_done, o_err, o_frame_count
  );
endinterface

// File: rtl/word_framer.sv
// Splits one inclusive byte-address range of samples into overlapping analysis frames,
// emitting start/end pairs over valid/ready and a done pulse with the frame count.
module word_framer #(
  parameter int FRAME_LEN   = 400,
  parameter int FRAME_STEP  = 160,
  parameter int ADDR_STRIDE = 2,
  parameter int MAX_FRAMES  = 1024
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  word_framer_if.slave  bus
);

  // Address math runs in 34 bits so any carry past 2^32 simply compares as beyond E.
  localparam logic [33:0] SPAN     = 34'((FRAME_LEN - 1) * ADDR_STRIDE);
  localparam logic [33:0] STEP_B   = 34'(FRAME_STEP * ADDR_STRIDE);
  localparam logic [33:0] STEP_B2  = 34'(2 * FRAME_STEP * ADDR_STRIDE);
  localparam logic [15:0] LAST_IDX = 16'(MAX_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    EMIT,
    DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] s_reg, s_next;
  logic [31:0] e_reg, e_next;
  logic [31:0] start_reg, start_next;
  logic [31:0] end_reg, end_next;
  logic [15:0] idx_reg, idx_next;
  logic [15:0] count_reg, count_next;
  logic [15:0] frame_count_reg, frame_count_next;
  logic        ready_reg, ready_next;
  logic        valid_reg, valid_next;
  logic        last_reg, last_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;

  logic [33:0] s_wide;
  logic [33:0] e_wide;
  logic [33:0] start_wide;

  assign s_wide     = {2'b00, s_reg};
  assign e_wide     = {2'b00, e_reg};
  assign start_wide = {2'b00, start_reg};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg       <= IDLE;
      s_reg           <= '0;
      e_reg           <= '0;
      start_reg       <= '0;
      end_reg         <= '0;
      idx_reg         <= '0;
      count_reg       <= '0;
      frame_count_reg <= '0;
      ready_reg       <= 1'b1;
      valid_reg       <= 1'b0;
      last_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      s_reg           <= s_next;
      e_reg           <= e_next;
      start_reg       <= start_next;
      end_reg         <= end_next;
      idx_reg         <= idx_next;
      count_reg       <= count_next;
      frame_count_reg <= frame_count_next;
      ready_reg       <= ready_next;
      valid_reg       <= valid_next;
      last_reg        <= last_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    s_next           = s_reg;
    e_next           = e_reg;
    start_next       = start_reg;
    end_next         = end_reg;
    idx_next         = idx_reg;
    count_next       = count_reg;
    frame_count_next = frame_count_reg;
    valid_next       = valid_reg;
    last_next        = last_reg;
    done_next        = 1'b0;
    err_next         = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (bus.i_start) begin
          s_next           = bus.i_start_addr;
          e_next           = bus.i_end_addr;
          idx_next         = '0;
          count_next       = '0;
          frame_count_next = '0;
          state_next       = CHECK;
        end
      end

      CHECK: begin
        if (e_reg < s_reg) begin
          state_next = DONE;
          done_next  = 1'b1;
          err_next   = 1'b1;
        end else if (s_wide + SPAN > e_wide) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          start_next = s_reg;
          end_next   = s_reg + SPAN[31:0];
          idx_next   = '0;
          valid_next = 1'b1;
          last_next  = (s_wide + STEP_B + SPAN > e_wide) || (LAST_IDX == 16'd0);
          state_next = EMIT;
        end
      end

      EMIT: begin
        if (valid_reg && bus.i_ready) begin
          count_next = count_reg + 16'd1;
          if (last_reg) begin
            valid_next       = 1'b0;
            last_next        = 1'b0;
            done_next        = 1'b1;
            frame_count_next = count_reg + 16'd1;
            state_next       = DONE;
          end else begin
            // Lookahead: the frame after the one being loaded decides o_last.
            start_next = start_reg + STEP_B[31:0];
            end_next   = end_reg + STEP_B[31:0];
            idx_next   = idx_reg + 16'd1;
            last_next  = (start_wide + STEP_B2 + SPAN > e_wide) ||
                         (idx_reg + 16'd1 == LAST_IDX);
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    ready_next = (state_next == IDLE);
  end

  assign bus.o_ready       = ready_reg;
  assign bus.o_valid       = valid_reg;
  assign bus.o_frame_start = start_reg;
  assign bus.o_frame_end   = end_reg;
  assign bus.o_frame_idx   = idx_reg;
  assign bus.o_last        = last_reg;
  assign bus.o_done        = done_reg;
  assign bus.o_err         = err_reg;
  assign bus.o_frame_count = frame_count_reg;

endmodule

// File: tb/tb_word_framer.sv
// Directed bench for word_framer: a vector table of words with hand-computed frames,
// plus a mid-word reset sequence. A second instance runs with MAX_FRAMES=2.
module tb_word_framer;

  logic        i_clk;
  logic        i_rstn;
  logic        start;
  logic        sel;
  logic        rdy;
  logic [31:0] saddr;
  logic [31:0] eaddr;

  int compared   = 0;
  int mismatched = 0;

  word_framer_if ifa ();
  word_framer_if ifb ();

  assign ifa.i_start      = start & ~sel;
  assign ifb.i_start      = start & sel;
  assign ifa.i_start_addr = saddr;
  assign ifb.i_start_addr = saddr;
  assign ifa.i_end_addr   = eaddr;
  assign ifb.i_end_addr   = eaddr;
  assign ifa.i_ready      = rdy;
  assign ifb.i_ready      = rdy;

  word_framer dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (ifa.slave)
  );

  word_framer #(.MAX_FRAMES(2)) dut2 (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (ifb.slave)
  );

  logic        c_ready, c_valid, c_last, c_done, c_err;
  logic [31:0] c_fs, c_fe;
  logic [15:0] c_idx, c_cnt;

  assign c_ready = sel ? ifb.o_ready       : ifa.o_ready;
  assign c_valid = sel ? ifb.o_valid       : ifa.o_valid;
  assign c_last  = sel ? ifb.o_last        : ifa.o_last;
  assign c_done  = sel ? ifb.o_done        : ifa.o_done;
  assign c_err   = sel ? ifb.o_err         : ifa.o_err;
  assign c_fs    = sel ? ifb.o_frame_start : ifa.o_frame_start;
  assign c_fe    = sel ? ifb.o_frame_end   : ifa.o_frame_end;
  assign c_idx   = sel ? ifb.o_frame_idx   : ifa.o_frame_idx;
  assign c_cnt   = sel ? ifb.o_frame_count : ifa.o_frame_count;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [8*8-1:0]  name;
    logic [31:0]     s;
    logic [31:0]     e;
    bit              use_b;
    int              stall_k;
    int              stall_n;
    int              xn;
    bit              xerr;
    logic [3:0][31:0] xs;
    logic [3:0][31:0] xe;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [8*8-1:0] nm, input logic [31:0] s,
                         input logic [31:0] e, input bit b, input int sk, input int sn,
                         input int n, input bit er);
    vecs[i].name    = nm;
    vecs[i].s       = s;
    vecs[i].e       = e;
    vecs[i].use_b   = b;
    vecs[i].stall_k = sk;
    vecs[i].stall_n = sn;
    vecs[i].xn      = n;
    vecs[i].xerr    = er;
    vecs[i].xs      = '0;
    vecs[i].xe      = '0;
  endtask

  task automatic accept(input logic [31:0] s, input logic [31:0] e);
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      @(negedge i_clk);
      ok = c_ready;
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: o_ready never rose");
    end
    saddr = s;
    eaddr = e;
    start = 1'b1;
    @(posedge i_clk);
    #1 start = 1'b0;
  endtask

  task automatic run_vec(input int v);
    int  nf;
    int  stalls_left;
    int  exp_cyc;
    bit  fin;
    sel = vecs[v].use_b;
    rdy = 1'b1;
    nf = 0;
    fin = 1'b0;
    stalls_left = vecs[v].stall_n;
    exp_cyc = 2 + vecs[v].xn + ((vecs[v].stall_k >= 0 && vecs[v].stall_k < vecs[v].xn) ? vecs[v].stall_n : 0);
    accept(vecs[v].s, vecs[v].e);
    for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
      @(negedge i_clk);
      if (c_valid) begin
        if (nf >= vecs[v].xn) begin
          chk("extra_frame", 32'(nf), 32'(vecs[v].xn));
        end else begin
          chk("frame_start", c_fs, vecs[v].xs[nf]);
          chk("frame_end", c_fe, vecs[v].xe[nf]);
          chk("frame_idx", 32'(c_idx), 32'(nf));
          chk("frame_last", 32'(c_last), 32'(nf == vecs[v].xn - 1));
        end
        if (nf == vecs[v].stall_k && stalls_left > 0) begin
          rdy = 1'b0;
          stalls_left--;
        end else begin
          rdy = 1'b1;
          nf++;
        end
      end
      if (c_done) begin
        chk("done_latency", 32'(cyc), 32'(exp_cyc));
        chk("done_no_valid", 32'(c_valid), 32'd0);
        chk("frame_count", 32'(c_cnt), 32'(vecs[v].xn));
        chk("err", 32'(c_err), 32'(vecs[v].xerr));
        chk("frames_seen", 32'(nf), 32'(vecs[v].xn));
        fin = 1'b1;
      end
    end
    if (!fin) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: vector %s produced no o_done", vecs[v].name);
    end
    rdy = 1'b1;
    @(negedge i_clk);
    chk("ready_after_done", 32'(c_ready), 32'd1);
    chk("count_held", 32'(c_cnt), 32'(vecs[v].xn));
    $display("word %s S=0x%08h E=0x%08h frames=%0d err=%0d", vecs[v].name,
             vecs[v].s, vecs[v].e, nf, c_err);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(ifa.o_ready), 32'd1);
    chk({tag, "_valid"}, 32'(ifa.o_valid), 32'd0);
    chk({tag, "_last"},  32'(ifa.o_last), 32'd0);
    chk({tag, "_done"},  32'(ifa.o_done), 32'd0);
    chk({tag, "_err"},   32'(ifa.o_err), 32'd0);
    chk({tag, "_fs"},    ifa.o_frame_start, 32'd0);
    chk({tag, "_fe"},    ifa.o_frame_end, 32'd0);
    chk({tag, "_idx"},   32'(ifa.o_frame_idx), 32'd0);
    chk({tag, "_cnt"},   32'(ifa.o_frame_count), 32'd0);
  endtask

  initial begin
    bit hit;
    i_rstn = 1'b0;
    start  = 1'b0;
    sel    = 1'b0;
    rdy    = 1'b1;
    saddr  = '0;
    eaddr  = '0;

    set_vec(0, "basic", 32'h1000, 32'h163E, 0, -1, 0, 3, 0);
    vecs[0].xs[0] = 32'h1000; vecs[0].xe[0] = 32'h131E;
    vecs[0].xs[1] = 32'h1140; vecs[0].xe[1] = 32'h145E;
    vecs[0].xs[2] = 32'h1280; vecs[0].xe[2] = 32'h159E;
    set_vec(1, "short", 32'h1000, 32'h131C, 0, -1, 0, 0, 0);
    set_vec(2, "reverse", 32'h2000, 32'h1FFE, 0, -1, 0, 0, 1);
    set_vec(3, "stall", 32'h1000, 32'h163E, 0, 1, 5, 3, 0);
    vecs[3].xs = vecs[0].xs;
    vecs[3].xe = vecs[0].xe;
    set_vec(4, "max2", 32'h1000, 32'h163E, 1, -1, 0, 2, 0);
    vecs[4].xs[0] = 32'h1000; vecs[4].xe[0] = 32'h131E;
    vecs[4].xs[1] = 32'h1140; vecs[4].xe[1] = 32'h145E;
    set_vec(5, "wrap", 32'hFFFFFA00, 32'hFFFFFFFE, 0, -1, 0, 3, 0);
    vecs[5].xs[0] = 32'hFFFFFA00; vecs[5].xe[0] = 32'hFFFFFD1E;
    vecs[5].xs[1] = 32'hFFFFFB40; vecs[5].xe[1] = 32'hFFFFFE5E;
    vecs[5].xs[2] = 32'hFFFFFC80; vecs[5].xe[2] = 32'hFFFFFF9E;
    set_vec(6, "exact", 32'h0, 32'h31E, 0, -1, 0, 1, 0);
    vecs[6].xs[0] = 32'h0; vecs[6].xe[0] = 32'h31E;

    repeat (3) @(negedge i_clk);
    chk_reset_values("rst");
    i_rstn = 1'b1;
    @(negedge i_clk);
    chk_reset_values("post_rst");

    for (int v = 0; v < 7; v++) run_vec(v);

    // Reset during frame 1, then confirm a fresh word still frames normally.
    sel = 1'b0;
    rdy = 1'b1;
    accept(32'h1000, 32'h163E);
    hit = 1'b0;
    for (int w = 0; w < 20 && !hit; w++) begin
      @(negedge i_clk);
      hit = ifa.o_valid && (ifa.o_frame_idx == 16'd1);
    end
    chk("reached_frame1", 32'(hit), 32'd1);
    i_rstn = 1'b0;
    #1;
    chk_reset_values("mid_rst");
    @(negedge i_clk);
    chk_reset_values("mid_rst_hold");
    i_rstn = 1'b1;
    @(negedge i_clk);
    chk("no_done_after_rst", 32'(ifa.o_done), 32'd0);
    $display("word mid_reset aborted at frame 1");
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
